chroma_key_calibrator: RTL and testbench
========================================

Name: chroma_key_calibrator

Overview:
- Produces the packed chroma-key threshold word consumed by the pipeline's chroma-key mode stage.
- On request, it samples a rectangular window of the foreground stream for one full frame. It tracks max red, min green and max blue inside that window.
- It then applies per-channel margins with saturation and publishes the result as the new green-screen filter.
- It sits beside the foreground input path and drives the filter control word.

Parameters:
R_WIDTH, 5, red channel width
G_WIDTH, 6, green channel width
B_WIDTH, 5, blue channel width
X_WIDTH, 11, pixel x coordinate width
Y_WIDTH, 10, pixel y coordinate width
R_MARGIN, 2, added to max red
G_MARGIN, 4, subtracted from min green
B_MARGIN, 2, added to max blue
COUNT_WIDTH, 20, sample counter width
PIXEL_SIZE (localparam), R_WIDTH+G_WIDTH+B_WIDTH, packed pixel width, layout {R,G,B}, R in MSBs

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
start  in  1  single-cycle calibration request
win_x0, win_x1  in  X_WIDTH each  inclusive window x bounds, latched on accepted start
win_y0, win_y1  in  Y_WIDTH each  inclusive window y bounds, latched on accepted start
frame_start  in  1  pulse, first pixel of a frame is next
frame_end  in  1  pulse, last pixel of a frame (may coincide with its pixel_valid)
pixel_valid  in  1  fg_pixel_in / pixel_x / pixel_y valid this cycle
pixel_x  in  X_WIDTH  coordinate of current pixel
pixel_y  in  Y_WIDTH  coordinate of current pixel
fg_pixel_in  in  PIXEL_SIZE  foreground pixel
ctrl_green_screen_filter  out  PIXEL_SIZE  packed {RED_PASS,GREEN_PASS,BLUE_PASS}
filter_updated  out  1  one-cycle pulse when filter changes
calib_empty  out  1  one-cycle pulse when a calibration saw zero in-window pixels
busy  out  1  high in any state except IDLE
sample_count  out  COUNT_WIDTH  in-window pixels counted in last/current calibration

Behaviour:
- Reset values (async on rst high): state IDLE; filter = {R=0, G=all ones, B=0} (0x07E0 at defaults); filter_updated=0; calib_empty=0; busy=0; sample_count=0; accumulators max_r=0, min_g=all ones, max_b=0.
- States:
  - IDLE: start=1 -> latch window, clear accumulators and sample_count -> WAIT_FRAME.
  - WAIT_FRAME: frame_start=1 -> SAMPLE. Pixels before frame_start are ignored.
  - SAMPLE:
    - Each cycle with pixel_valid and x0<=pixel_x<=x1 and y0<=pixel_y<=y1: update max_r, min_g, max_b; sample_count++ (saturates at all ones).
    - frame_end=1 -> DONE. A valid in-window pixel in the same cycle is included.
    - frame_start in SAMPLE is ignored.
  - DONE (exactly one cycle) -> IDLE:
    - sample_count>0: filter <= {min(max_r+R_MARGIN, 2^R_WIDTH-1), max(min_g-G_MARGIN, 0), min(max_b+B_MARGIN, 2^B_WIDTH-1)}; filter_updated=1.
    - sample_count==0: filter unchanged; calib_empty=1.
- Arithmetic: margin sums use one extra bit, then clamp; no wrap-around permitted.
- Latency: frame_end sampled in cycle N -> DONE in N+1 -> new filter and pulse visible in N+2. busy drops in N+2.
- Filter holds its value between calibrations. It is never partially updated and never changes while busy before DONE.
- start while busy is ignored (no restart, window not re-latched). start in the DONE cycle is also ignored.
- Inverted window (x0>x1 or y0>y1) matches no pixel and ends in calib_empty.
- frame_start and frame_end in the same cycle in WAIT_FRAME: go to SAMPLE; frame_end ignored.
- rst mid-operation: immediate return to reset values, including filter default; no pulse generated.

Test Plan:
- Defaults, window (10,10)-(12,11), six in-window pixels with max R=5, min G=40, max B=3, plus out-of-window pixels R=31,G=0,B=31 -> filter 0x3C85 (R=7,G=36,B=5), filter_updated one cycle, sample_count=6.
- In-window pixel R=30,G=2,B=31 only -> saturation gives filter 0xF81F (R=31,G=0,B=31).
- Window x0=20,x1=10 for a full frame -> calib_empty pulse, filter stays 0x07E0, sample_count=0, filter_updated never asserts.
- Last in-window pixel (R=9) with pixel_valid coincident with frame_end -> included, RED_PASS=11; filter visible exactly 2 cycles after frame_end; busy low same cycle.
- start pulsed again mid-SAMPLE with a different window -> ignored, result matches first window. Pixels before frame_start are ignored.
- Complete a calibration to 0x3C85, then start a new one and assert rst mid-SAMPLE -> filter=0x07E0, busy=0, sample_count=0, no pulses. A following calibration runs normally.

Source files
------------

// File: rtl/chroma_key_calibrator.sv
// Chroma-key threshold calibrator.
// Samples a rectangular window of the foreground stream for one frame,
// tracks max red / min green / max blue, then publishes margined and
// saturated thresholds as the packed green-screen filter word {R,G,B}.
module chroma_key_calibrator #(
  parameter int unsigned R_WIDTH     = 5,
  parameter int unsigned G_WIDTH     = 6,
  parameter int unsigned B_WIDTH     = 5,
  parameter int unsigned X_WIDTH     = 11,
  parameter int unsigned Y_WIDTH     = 10,
  parameter int unsigned R_MARGIN    = 2,
  parameter int unsigned G_MARGIN    = 4,
  parameter int unsigned B_MARGIN    = 2,
  parameter int unsigned COUNT_WIDTH = 20
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [X_WIDTH-1:0]                 win_x0,
  input  logic [X_WIDTH-1:0]                 win_x1,
  input  logic [Y_WIDTH-1:0]                 win_y0,
  input  logic [Y_WIDTH-1:0]                 win_y1,
  input  logic                               frame_start,
  input  logic                               frame_end,
  input  logic                               pixel_valid,
  input  logic [X_WIDTH-1:0]                 pixel_x,
  input  logic [Y_WIDTH-1:0]                 pixel_y,
  input  logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0] fg_pixel_in,
  output logic [R_WIDTH+G_WIDTH+B_WIDTH-1:0] ctrl_green_screen_filter,
  output logic                               filter_updated,
  output logic                               calib_empty,
  output logic                               busy,
  output logic [COUNT_WIDTH-1:0]             sample_count
);

  localparam int unsigned PIXEL_SIZE = R_WIDTH + G_WIDTH + B_WIDTH;
  localparam int unsigned RS_WIDTH   = R_WIDTH + 1;
  localparam int unsigned GS_WIDTH   = G_WIDTH + 1;
  localparam int unsigned BS_WIDTH   = B_WIDTH + 1;

  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX     = '1;
  localparam logic [PIXEL_SIZE-1:0]  FILTER_RESET  =
    {{R_WIDTH{1'b0}}, {G_WIDTH{1'b1}}, {B_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FRAME = 2'd1,
    SAMPLE     = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t                  state_q;

  // Latched calibration window
  logic [X_WIDTH-1:0]      x0_q;
  logic [X_WIDTH-1:0]      x1_q;
  logic [Y_WIDTH-1:0]      y0_q;
  logic [Y_WIDTH-1:0]      y1_q;

  // Per-channel accumulators
  logic [R_WIDTH-1:0]      max_r_q;
  logic [G_WIDTH-1:0]      min_g_q;
  logic [B_WIDTH-1:0]      max_b_q;
  logic [COUNT_WIDTH-1:0]  count_q;

  // Registered outputs
  logic [PIXEL_SIZE-1:0]   filter_q;
  logic                    updated_q;
  logic                    empty_q;
  logic                    busy_q;

  // Combinational next values
  logic [R_WIDTH-1:0]      pix_r;
  logic [G_WIDTH-1:0]      pix_g;
  logic [B_WIDTH-1:0]      pix_b;
  logic                    in_win;
  logic                    hit;
  logic [R_WIDTH-1:0]      max_r_d;
  logic [G_WIDTH-1:0]      min_g_d;
  logic [B_WIDTH-1:0]      max_b_d;
  logic [COUNT_WIDTH-1:0]  count_d;
  logic [RS_WIDTH-1:0]     r_sum;
  logic [GS_WIDTH-1:0]     g_diff;
  logic [BS_WIDTH-1:0]     b_sum;
  logic [R_WIDTH-1:0]      red_pass;
  logic [G_WIDTH-1:0]      green_pass;
  logic [B_WIDTH-1:0]      blue_pass;
  logic [PIXEL_SIZE-1:0]   filter_d;

  // Pixel decode, window hit test, accumulator updates and margined thresholds
  always_comb begin
    pix_r      = fg_pixel_in[PIXEL_SIZE-1 -: R_WIDTH];
    pix_g      = fg_pixel_in[B_WIDTH +: G_WIDTH];
    pix_b      = fg_pixel_in[B_WIDTH-1:0];

    // An inverted window fails one of the two bounds for every pixel
    in_win     = (pixel_x >= x0_q) && (pixel_x <= x1_q) &&
                 (pixel_y >= y0_q) && (pixel_y <= y1_q);
    hit        = pixel_valid && in_win;

    max_r_d    = (pix_r > max_r_q) ? pix_r : max_r_q;
    min_g_d    = (pix_g < min_g_q) ? pix_g : min_g_q;
    max_b_d    = (pix_b > max_b_q) ? pix_b : max_b_q;
    count_d    = (count_q == COUNT_MAX) ? count_q : count_q + COUNT_WIDTH'(1);

    // One guard bit per channel: carry means clamp high, borrow means clamp to zero
    r_sum      = {1'b0, max_r_q} + RS_WIDTH'(R_MARGIN);
    g_diff     = {1'b0, min_g_q} - GS_WIDTH'(G_MARGIN);
    b_sum      = {1'b0, max_b_q} + BS_WIDTH'(B_MARGIN);

    red_pass   = r_sum[R_WIDTH]  ? {R_WIDTH{1'b1}} : r_sum[R_WIDTH-1:0];
    green_pass = g_diff[G_WIDTH] ? {G_WIDTH{1'b0}} : g_diff[G_WIDTH-1:0];
    blue_pass  = b_sum[B_WIDTH]  ? {B_WIDTH{1'b1}} : b_sum[B_WIDTH-1:0];

    filter_d   = {red_pass, green_pass, blue_pass};
  end

  // Calibration FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      x0_q      <= '0;
      x1_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      max_r_q   <= '0;
      min_g_q   <= '1;
      max_b_q   <= '0;
      count_q   <= '0;
      filter_q  <= FILTER_RESET;
      updated_q <= 1'b0;
      empty_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      updated_q <= 1'b0;
      empty_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start) begin
            x0_q    <= win_x0;
            x1_q    <= win_x1;
            y0_q    <= win_y0;
            y1_q    <= win_y1;
            max_r_q <= '0;
            min_g_q <= '1;
            max_b_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b1;
            state_q <= WAIT_FRAME;
          end
        end

        WAIT_FRAME: begin
          // A frame_end coinciding with frame_start belongs to the previous frame
          if (frame_start) begin
            state_q <= SAMPLE;
          end
        end

        SAMPLE: begin
          // The pixel presented alongside frame_end is still part of the frame
          if (hit) begin
            max_r_q <= max_r_d;
            min_g_q <= min_g_d;
            max_b_q <= max_b_d;
            count_q <= count_d;
          end
          if (frame_end) begin
            state_q <= DONE;
          end
        end

        DONE: begin
          if (count_q != '0) begin
            filter_q  <= filter_d;
            updated_q <= 1'b1;
          end else begin
            empty_q   <= 1'b1;
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ctrl_green_screen_filter = filter_q;
  assign filter_updated           = updated_q;
  assign calib_empty              = empty_q;
  assign busy                     = busy_q;
  assign sample_count             = count_q;

endmodule

// File: tb/tb_chroma_key_calibrator.sv
// Bench for chroma_key_calibrator: directed and randomized calibrations,
// expected results queued by a reference model and popped by a monitor.
module tb_chroma_key_calibrator;

  localparam int XW = 11;
  localparam int YW = 10;
  localparam int PW = 16;
  localparam int CW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [XW-1:0] win_x0, win_x1;
  logic [YW-1:0] win_y0, win_y1;
  logic          frame_start, frame_end, pixel_valid;
  logic [XW-1:0] pixel_x;
  logic [YW-1:0] pixel_y;
  logic [PW-1:0] fg_pixel_in;
  logic [PW-1:0] ctrl_green_screen_filter;
  logic          filter_updated, calib_empty, busy;
  logic [CW-1:0] sample_count;

  chroma_key_calibrator dut (
    .clk                      (clk),
    .rst                      (rst),
    .start                    (start),
    .win_x0                   (win_x0),
    .win_x1                   (win_x1),
    .win_y0                   (win_y0),
    .win_y1                   (win_y1),
    .frame_start              (frame_start),
    .frame_end                (frame_end),
    .pixel_valid              (pixel_valid),
    .pixel_x                  (pixel_x),
    .pixel_y                  (pixel_y),
    .fg_pixel_in              (fg_pixel_in),
    .ctrl_green_screen_filter (ctrl_green_screen_filter),
    .filter_updated           (filter_updated),
    .calib_empty              (calib_empty),
    .busy                     (busy),
    .sample_count             (sample_count)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int r; int g; int b; } pix_t;
  typedef struct { bit empty; int filt; int cnt; int cyc; } exp_t;

  pix_t frame_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   exp_filter = 'h07E0;
  int   mx0, mx1, my0, my1;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int pack(input int r, input int g, input int b);
    return r * 2048 + g * 32 + b;
  endfunction

  // Reference: collect in-window pixels of the frame, then apply margins and clamp
  function automatic exp_t model(input int end_cyc);
    exp_t e;
    int cnt = 0;
    int mr = 0;
    int mg = 63;
    int mb = 0;
    int r, g, b;
    foreach (frame_q[i]) begin
      if (frame_q[i].x >= mx0 && frame_q[i].x <= mx1 &&
          frame_q[i].y >= my0 && frame_q[i].y <= my1) begin
        cnt++;
        if (frame_q[i].r > mr) mr = frame_q[i].r;
        if (frame_q[i].g < mg) mg = frame_q[i].g;
        if (frame_q[i].b > mb) mb = frame_q[i].b;
      end
    end
    r = (mr + 2 > 31) ? 31 : mr + 2;
    g = (mg - 4 < 0) ? 0 : mg - 4;
    b = (mb + 2 > 31) ? 31 : mb + 2;
    e.empty = (cnt == 0);
    e.cnt   = cnt;
    e.filt  = pack(r, g, b);
    e.cyc   = end_cyc + 2;
    return e;
  endfunction

  // Monitor: pops an expectation per pulse; filter must otherwise hold
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (filter_updated || calib_empty) begin
        if (exp_q.size() == 0) begin
          chk("spurious_pulse", int'({filter_updated, calib_empty}), 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", int'({filter_updated, calib_empty}), e.empty ? 1 : 2);
          chk("pulse_cycle", cyc, e.cyc);
          chk("sample_count", int'(sample_count), e.cnt);
          chk("busy_at_pulse", int'(busy), 0);
          if (!e.empty) exp_filter = e.filt;
        end
      end
      chk("filter_value", int'(ctrl_green_screen_filter), exp_filter);
    end
  end

  task automatic add_pix(input int x, input int y, input int r, input int g, input int b);
    pix_t p;
    p.x = x; p.y = y; p.r = r; p.g = g; p.b = b;
    frame_q.push_back(p);
  endtask

  task automatic drive_pix(input pix_t p);
    pixel_valid = 1'b1;
    pixel_x     = XW'(p.x);
    pixel_y     = YW'(p.y);
    fg_pixel_in = PW'(pack(p.r, p.g, p.b));
  endtask

  task automatic do_start(input int x0, input int x1, input int y0, input int y1);
    @(posedge clk); #1;
    win_x0 = XW'(x0); win_x1 = XW'(x1);
    win_y0 = YW'(y0); win_y1 = YW'(y1);
    start  = 1'b1;
    mx0 = x0; mx1 = x1; my0 = y0; my1 = y1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  // One frame: optional pre-frame pixels, gaps, mid-frame restart attempt, start in DONE
  task automatic send_frame(input int pre, input bit coinc, input int restart_at,
                            input bit done_start);
    pix_t pp;
    exp_t e;
    int   last;
    int   end_cyc;
    last = frame_q.size() - 1;
    pp.x = mx0; pp.y = my0; pp.r = 31; pp.g = 0; pp.b = 31;
    for (int i = 0; i < pre; i++) begin
      @(posedge clk); #1;
      drive_pix(pp);
    end
    @(posedge clk); #1;
    pixel_valid = 1'b0;
    frame_start = 1'b1;
    foreach (frame_q[i]) begin
      @(posedge clk); #1;
      frame_start = 1'b0;
      start       = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        pixel_valid = 1'b0;
        pixel_x     = XW'(mx0);
        pixel_y     = YW'(my0);
        fg_pixel_in = PW'($urandom);
        @(posedge clk); #1;
      end
      drive_pix(frame_q[i]);
      if (i == restart_at) begin
        start = 1'b1; frame_start = 1'b1;
        win_x0 = '0; win_x1 = '1; win_y0 = '0; win_y1 = '1;
      end
      frame_end = coinc && (i == last);
    end
    if (!coinc || last < 0) begin
      @(posedge clk); #1;
      pixel_valid = 1'b0; start = 1'b0; frame_start = 1'b0;
      frame_end   = 1'b1;
    end
    end_cyc = cyc;
    e = model(end_cyc);
    exp_q.push_back(e);
    @(posedge clk); #1;
    frame_end = 1'b0; pixel_valid = 1'b0; frame_start = 1'b0;
    start = done_start;
    win_x0 = '0; win_x1 = '1; win_y0 = '0; win_y1 = '1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pulse_seen", exp_q.size(), 0);
    chk("idle_after_calib", int'(busy), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_filter = 'h07E0;
    exp_q.delete();
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(sample_count), 0);
    chk("rst_filter", int'(ctrl_green_screen_filter), 'h07E0);
    chk("rst_pulses", int'({filter_updated, calib_empty}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pixel_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0; start = 1'b0;
  endtask

  task automatic load_t1_pixels();
    frame_q.delete();
    add_pix(10, 10, 5, 50, 1);
    add_pix(9, 10, 31, 0, 31);
    add_pix(11, 10, 2, 40, 3);
    add_pix(12, 10, 1, 45, 0);
    add_pix(13, 11, 31, 0, 31);
    add_pix(10, 11, 3, 60, 2);
    add_pix(11, 12, 31, 0, 31);
    add_pix(11, 11, 4, 41, 1);
    add_pix(11, 9, 31, 0, 31);
    add_pix(12, 11, 0, 63, 3);
  endtask

  initial begin
    int n, rs;
    rst = 1'b1; start = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    pixel_valid = 1'b0; pixel_x = '0; pixel_y = '0; fg_pixel_in = '0;
    win_x0 = '0; win_x1 = '0; win_y0 = '0; win_y1 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_count", int'(sample_count), 0);
    chk("reset_filter", int'(ctrl_green_screen_filter), 'h07E0);

    // Inverted window: empty calibration, filter stays at default
    do_start(20, 10, 0, 100);
    frame_q.delete();
    for (int i = 10; i <= 20; i++) add_pix(i, 5, 7, 7, 7);
    send_frame(0, 0, -1, 0);
    chk("inverted_filter", int'(ctrl_green_screen_filter), 'h07E0);
    chk("inverted_count", int'(sample_count), 0);

    // Basic window with out-of-window extremes; pre-frame pixels ignored
    do_start(10, 12, 10, 11);
    load_t1_pixels();
    send_frame(2, 0, -1, 0);
    chk("basic_filter", int'(ctrl_green_screen_filter), 'h3C85);
    chk("basic_count", int'(sample_count), 6);

    // Last in-window pixel coincident with frame_end; start in DONE ignored
    do_start(0, 3, 0, 0);
    frame_q.delete();
    add_pix(0, 0, 4, 50, 2);
    add_pix(2, 0, 1, 20, 3);
    add_pix(3, 0, 9, 33, 0);
    send_frame(0, 1, -1, 1);
    chk("coinc_red", int'(ctrl_green_screen_filter[15:11]), 11);

    // Saturation on all three channels
    do_start(5, 5, 7, 7);
    frame_q.delete();
    add_pix(6, 7, 0, 63, 0);
    add_pix(5, 7, 30, 2, 31);
    send_frame(0, 0, -1, 0);
    chk("saturate_filter", int'(ctrl_green_screen_filter), 'hF81F);

    // Restart attempt mid-frame with a wider window is ignored
    do_start(10, 12, 10, 11);
    load_t1_pixels();
    send_frame(3, 0, 4, 0);
    chk("restart_filter", int'(ctrl_green_screen_filter), 'h3C85);

    // Reset mid-sample, then a normal calibration
    do_start(5, 5, 7, 7);
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    pixel_valid = 1'b1; pixel_x = XW'(5); pixel_y = YW'(7);
    fg_pixel_in = PW'(pack(30, 2, 31));
    @(posedge clk); #1;
    do_reset();
    repeat (2) @(posedge clk);
    do_start(10, 12, 10, 11);
    load_t1_pixels();
    send_frame(0, 1, -1, 0);
    chk("after_reset_filter", int'(ctrl_green_screen_filter), 'h3C85);

    // Randomized calibrations
    for (int t = 0; t < 12; t++) begin
      do_start($urandom_range(0, 24), $urandom_range(4, 31),
               $urandom_range(0, 24), $urandom_range(4, 31));
      frame_q.delete();
      n = $urandom_range(0, 14);
      for (int i = 0; i < n; i++)
        add_pix($urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 31));
      rs = (n > 0 && $urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
      send_frame($urandom_range(0, 2), 1'($urandom_range(0, 1)), rs,
                 1'($urandom_range(0, 1)));
    end

    repeat (5) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
